// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment display blocks: active-low segment
// patterns ({g,f,e,d,c,b,a}), scan state encoding and the digit-count limit.
package disp_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int IDX_W      = $clog2(MAX_DIGITS);

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/bcd7seg_dec.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd7seg_dec
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  // Map each BCD code onto its segment pattern.
  always_comb begin
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode 7-segment display.
// Rotates one lit digit per slot, blanks the start of each slot against ghosting,
// shows a per-frame snapshot of the BCD input and blanks leading zeros on request.
// All outputs are registered: they describe the previous cycle's scan position.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 8,
  parameter int PW        = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic                  lz_en,
  input  logic [4*DIGITS-1:0]   digits_bcd,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     com_n,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  localparam logic [PW-1:0]    PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]    PRE_BLANK = PW'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // Scan position and state.
  logic [PW-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scan_state_t      state_q, state_d, eff_state;
  logic             fd_d;

  // Frame snapshot of the displayed data.
  logic [4*DIGITS-1:0] snap_bcd_q, snap_bcd_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                capture;

  // Per-slot data selection and output stage.
  logic [3:0]        cur_bcd;
  logic              cur_dp;
  logic              upper_zero;
  logic              lz_blank;
  logic [6:0]        dec_seg;
  logic [6:0]        seg_d;
  logic              dp_d;
  logic [DIGITS-1:0] com_d;

  // Next prescaler/index/state: en=0 beats sync_clr, which beats the slot wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pre_d   = pre_q;
    idx_d   = idx_q;
    state_d = state_q;
    fd_d    = 1'b0;
    if (!en) begin
      pre_d   = '0;
      idx_d   = '0;
      state_d = OFF;
    end else begin
      if (sync_clr) begin
        pre_d = '0;
        idx_d = '0;
      end else if (pre_q == PRE_LAST) begin
        pre_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        fd_d  = (idx_q == IDX_LAST);
      end else begin
        pre_d = pre_q + PW'(1);
      end
      state_d = (pre_d < PRE_BLANK) ? BLANK : SHOW;
    end
  end

  // A low en darkens the display at the very next edge, even mid-slot.
  assign eff_state = en ? state_q : OFF;

  // Capture new data at slot 0, prescaler 0; the bypass lets that cycle use it too.
  assign capture    = en && (pre_q == '0) && (idx_q == '0);
  assign snap_bcd_d = capture ? digits_bcd : snap_bcd_q;
  assign snap_dp_d  = capture ? dp_mask    : snap_dp_q;

  // Select the current digit and decide leading-zero blanking from the top digit down.
  always_comb begin
    cur_bcd    = '0;
    cur_dp     = 1'b0;
    upper_zero = 1'b1;
    lz_blank   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (snap_bcd_d[4*i +: 4] != 4'd0) upper_zero = 1'b0;
      if (IDX_W'(i) == idx_q) begin
        cur_bcd  = snap_bcd_d[4*i +: 4];
        cur_dp   = snap_dp_d[i];
        lz_blank = lz_en && (i != 0) && upper_zero;
      end
    end
  end

  bcd7seg_dec u_dec (
    .bcd   (cur_bcd),
    .seg_n (dec_seg)
  );

  // Drive one common and the decoded segments only while showing.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    com_d = '1;
    if (eff_state == SHOW) begin
      seg_d = lz_blank ? SEG_OFF : dec_seg;
      dp_d  = ~cur_dp;
      for (int i = 0; i < DIGITS; i++) com_d[i] = (IDX_W'(i) != idx_q);
    end
  end

  // Scan counters, snapshot and registered pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q      <= '0;
      idx_q      <= '0;
      state_q    <= OFF;
      // NOTE: the snapshot is reset so a freshly reset display never shows stale digits.
      snap_bcd_q <= '0;
      snap_dp_q  <= '0;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      com_n      <= '1;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      snap_bcd_q <= snap_bcd_d;
      snap_dp_q  <= snap_dp_d;
      seg_n      <= seg_d;
      dp_n       <= dp_d;
      com_n      <= com_d;
      digit_idx  <= idx_q;
      frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl (DIGITS=6, SCAN_DIV=16, BLANK_CYC=2).
module tb_disp_scan_ctrl;

  localparam int DIGITS    = 6;
  localparam int SCAN_DIV  = 16;
  localparam int BLANK_CYC = 2;
  localparam int PW        = 4;
  localparam int FRAME     = DIGITS * SCAN_DIV;

  localparam logic [6:0] REF_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              sync_clr = 1'b0;
  logic              lz_en = 1'b0;
  logic [23:0]       digits_bcd = '0;
  logic [5:0]        dp_mask = '0;
  logic [6:0]        seg_n;
  logic              dp_n;
  logic [5:0]        com_n;
  logic [2:0]        digit_idx;
  logic              frame_done;

  disp_scan_ctrl #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .PW        (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sync_clr   (sync_clr),
    .lz_en      (lz_en),
    .digits_bcd (digits_bcd),
    .dp_mask    (dp_mask),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .com_n      (com_n),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: position within the frame as one integer, frame-level snapshot.
  typedef struct {
    int          pos;
    logic [23:0] snap;
    logic [5:0]  dp;
    logic [6:0]  seg;
    logic        dpn;
    logic [5:0]  com;
    logic [2:0]  idx;
    logic        fd;
  } model_t;

  function automatic model_t model_step(input model_t cur, input logic en_i, input logic sc_i,
                                        input logic lz_i, input logic [23:0] d_i,
                                        input logic [5:0] dp_i);
    model_t n = cur;
    int slot  = cur.pos / SCAN_DIV;
    int phase = cur.pos % SCAN_DIV;
    logic [23:0] upper;
    if (en_i && cur.pos == 0) begin
      n.snap = d_i;
      n.dp   = dp_i;
    end
    upper = n.snap >> (4 * slot);
    n.idx = 3'(slot);
    n.fd  = en_i && !sc_i && (cur.pos == FRAME - 1);
    n.seg = 7'h7F;
    n.dpn = 1'b1;
    n.com = 6'h3F;
    if (en_i && phase >= BLANK_CYC) begin
      n.com = ~(6'd1 << slot);
      n.dpn = ~n.dp[slot];
      if (!(lz_i && slot > 0 && upper == 24'd0)) n.seg = REF_SEG[upper[3:0]];
    end
    n.pos = (!en_i || sc_i) ? 0 : (cur.pos + 1) % FRAME;
    return n;
  endfunction

  model_t m_cur, m_nxt;
  logic   chk_model = 1'b0;

  always_comb m_nxt = model_step(m_cur, en, sync_clr, lz_en, digits_bcd, dp_mask);

  always @(posedge clk or posedge rst) begin
    if (rst) m_cur <= '{pos: 0, snap: '0, dp: '0, seg: 7'h7F, dpn: 1'b1, com: 6'h3F, idx: '0, fd: 1'b0};
    else     m_cur <= m_nxt;
  end

  always @(negedge clk) begin
    if (chk_model) begin
      check("rnd_seg_n", 32'(seg_n), 32'(m_cur.seg));
      check("rnd_dp_n", 32'(dp_n), 32'(m_cur.dpn));
      check("rnd_com_n", 32'(com_n), 32'(m_cur.com));
      check("rnd_digit_idx", 32'(digit_idx), 32'(m_cur.idx));
      check("rnd_frame_done", 32'(frame_done), 32'(m_cur.fd));
    end
  end

  // Sequencing helpers: t counts posedges since the cycle that held prescaler 0, slot 0.
  int t = 0;

  task automatic restart();
    sync_clr = 1'b1;
    @(posedge clk);
    t = 0;
    @(negedge clk);
    sync_clr = 1'b0;
  endtask

  // Wait until the outputs describe frame position p, then sit on the falling edge.
  task automatic go(input int p);
    repeat (p + 1 - t) @(posedge clk);
    t = p + 1;
    @(negedge clk);
  endtask

  function automatic logic [23:0] rand_digits();
    logic [23:0] d = '0;
    int top = $urandom_range(0, 5);
    for (int k = 0; k <= top; k++) begin
      case ($urandom_range(0, 3))
        0:       d[4*k +: 4] = 4'd0;
        3:       d[4*k +: 4] = 4'($urandom_range(10, 15));
        default: d[4*k +: 4] = 4'($urandom_range(0, 9));
      endcase
    end
    return d;
  endfunction

  typedef struct {
    logic [23:0] digits;
    logic [5:0]  dp;
    logic        lz;
    int          slot;
    logic [6:0]  seg;
    logic        dpn;
    logic [5:0]  com;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{24'h123456, 6'h00, 1'b0, 0, 7'h02, 1'b1, 6'h3E};
    vecs[1]  = '{24'h123456, 6'h00, 1'b0, 5, 7'h79, 1'b1, 6'h1F};
    vecs[2]  = '{24'h123456, 6'h00, 1'b0, 2, 7'h19, 1'b1, 6'h3B};
    vecs[3]  = '{24'h000042, 6'h00, 1'b1, 2, 7'h7F, 1'b1, 6'h3B};
    vecs[4]  = '{24'h000042, 6'h00, 1'b1, 5, 7'h7F, 1'b1, 6'h1F};
    vecs[5]  = '{24'h000042, 6'h00, 1'b1, 1, 7'h19, 1'b1, 6'h3D};
    vecs[6]  = '{24'h000042, 6'h00, 1'b1, 0, 7'h24, 1'b1, 6'h3E};
    vecs[7]  = '{24'h000042, 6'h00, 1'b0, 3, 7'h40, 1'b1, 6'h37};
    vecs[8]  = '{24'h000C00, 6'h04, 1'b0, 2, 7'h3F, 1'b0, 6'h3B};
    vecs[9]  = '{24'h000C00, 6'h04, 1'b0, 1, 7'h40, 1'b1, 6'h3D};
    vecs[10] = '{24'h000C00, 6'h04, 1'b1, 3, 7'h7F, 1'b1, 6'h37};
    vecs[11] = '{24'h000000, 6'h21, 1'b1, 0, 7'h40, 1'b0, 6'h3E};
    vecs[12] = '{24'h000000, 6'h21, 1'b1, 5, 7'h7F, 1'b0, 6'h1F};
    vecs[13] = '{24'h7890AB, 6'h00, 1'b1, 4, 7'h00, 1'b1, 6'h2F};
    vecs[14] = '{24'h7890AB, 6'h00, 1'b1, 2, 7'h40, 1'b1, 6'h3B};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_seg_n", 32'(seg_n), 32'h7F);
    check("reset_dp_n", 32'(dp_n), 32'h1);
    check("reset_com_n", 32'(com_n), 32'h3F);
    check("reset_digit_idx", 32'(digit_idx), 32'h0);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    rst = 1'b0;

    // First enable: blank interval boundaries of slot 0 and the slot-1 handover.
    digits_bcd = 24'h123456;
    en = 1'b1;
    t = 0;
    go(1);
    check("blank_last_com_n", 32'(com_n), 32'h3F);
    check("blank_last_seg_n", 32'(seg_n), 32'h7F);
    go(2);
    check("show_first_com_n", 32'(com_n), 32'h3E);
    check("show_first_seg_n", 32'(seg_n), 32'h02);
    go(15);
    check("slot0_last_com_n", 32'(com_n), 32'h3E);
    go(16);
    check("slot1_blank_com_n", 32'(com_n), 32'h3F);
    check("slot1_blank_idx", 32'(digit_idx), 32'h1);

    // Table of snapshot / decode / blanking vectors.
    for (int v = 0; v < 15; v++) begin
      digits_bcd = vecs[v].digits;
      dp_mask    = vecs[v].dp;
      lz_en      = vecs[v].lz;
      restart();
      go(SCAN_DIV * vecs[v].slot + 8);
      check($sformatf("vec%0d_seg_n", v), 32'(seg_n), 32'(vecs[v].seg));
      check($sformatf("vec%0d_dp_n", v), 32'(dp_n), 32'(vecs[v].dpn));
      check($sformatf("vec%0d_com_n", v), 32'(com_n), 32'(vecs[v].com));
      check($sformatf("vec%0d_digit_idx", v), 32'(digit_idx), 32'(vecs[v].slot));
    end

    // Mid-frame data change only takes effect at the next slot-0 capture.
    digits_bcd = 24'h123456;
    dp_mask    = 6'h00;
    lz_en      = 1'b0;
    restart();
    go(3 * SCAN_DIV + 8);
    digits_bcd = 24'h654321;
    go(4 * SCAN_DIV + 8);
    check("midframe_old_slot4", 32'(seg_n), 32'h24);
    go(5 * SCAN_DIV + 8);
    check("midframe_old_slot5", 32'(seg_n), 32'h79);
    go(FRAME + 8);
    check("midframe_new_slot0", 32'(seg_n), 32'h79);
    go(FRAME + 4 * SCAN_DIV + 8);
    check("midframe_new_slot4", 32'(seg_n), 32'h12);

    // frame_done pulse position, then sync_clr colliding with the slot-5 wrap.
    digits_bcd = 24'h123456;
    restart();
    go(FRAME - 2);
    check("fd_before_wrap", 32'(frame_done), 32'h0);
    go(FRAME - 1);
    check("fd_at_wrap", 32'(frame_done), 32'h1);
    go(FRAME);
    check("fd_after_wrap", 32'(frame_done), 32'h0);
    go(2 * FRAME - 2);
    sync_clr   = 1'b1;
    digits_bcd = 24'h999999;
    @(posedge clk);
    @(negedge clk);
    sync_clr = 1'b0;
    t = 0;
    check("syncwrap_frame_done", 32'(frame_done), 32'h0);
    check("syncwrap_digit_idx", 32'(digit_idx), 32'h5);
    go(8);
    check("syncwrap_next_idx", 32'(digit_idx), 32'h0);
    check("syncwrap_fresh_seg", 32'(seg_n), 32'h10);
    go(FRAME - 1);
    check("syncwrap_next_fd", 32'(frame_done), 32'h1);

    // en dropped during slot 4 SHOW, then re-raised.
    digits_bcd = 24'h123456;
    restart();
    go(4 * SCAN_DIV + 8);
    check("endrop_before_com", 32'(com_n), 32'h2F);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("endrop_com_n", 32'(com_n), 32'h3F);
    check("endrop_seg_n", 32'(seg_n), 32'h7F);
    @(posedge clk);
    @(negedge clk);
    check("endrop_idx", 32'(digit_idx), 32'h0);
    en = 1'b1;
    t = 0;
    go(8);
    check("enrise_com_n", 32'(com_n), 32'h3E);
    check("enrise_seg_n", 32'(seg_n), 32'h02);

    // Asynchronous reset in the middle of a lit slot.
    dp_mask = 6'h3F;
    restart();
    go(2 * SCAN_DIV + 8);
    check("prerst_dp_n", 32'(dp_n), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("asyncrst_seg_n", 32'(seg_n), 32'h7F);
    check("asyncrst_dp_n", 32'(dp_n), 32'h1);
    check("asyncrst_com_n", 32'(com_n), 32'h3F);
    check("asyncrst_digit_idx", 32'(digit_idx), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    go(2);
    check("postrst_com_n", 32'(com_n), 32'h3E);
    check("postrst_seg_n", 32'(seg_n), 32'h02);

    // Randomized traffic against the reference model.
    chk_model = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (en) begin
        if ($urandom_range(0, 299) == 0) en = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        en = 1'b1;
      end
      sync_clr = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 29) == 0) digits_bcd = rand_digits();
      if ($urandom_range(0, 29) == 0) dp_mask = 6'($urandom);
      if ($urandom_range(0, 99) == 0) lz_en = ~lz_en;
      @(posedge clk);
      @(negedge clk);
    end
    chk_model = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Time-multiplexed scan controller for the stopwatch/clock 7-segment display. It shares one BCD-to-7-segment decoder across DIGITS common-cathode digits. It sequences the digit-select index, inserts an anti-ghosting blank interval in each slot, and applies frame-coherent data capture with leading-zero blanking. It sits between the time-keeping counters (BCD digit vector) and the board pins.

Parameters:
DIGITS, 6, number of digits scanned (legal 2..8); index 0 = least significant.
SCAN_DIV, 1000, clk cycles per digit slot (legal >= 2).
BLANK_CYC, 8, cycles at the start of each slot with all commons off (legal 0..SCAN_DIV-1).
PW, 10, prescaler width; must satisfy 2^PW >= SCAN_DIV.

Ports:
clk  in  1  system clock
rst  in  1  reset
en  in  1  scan enable; 0 = display dark, counters held at 0
sync_clr  in  1  synchronous restart of scan at slot 0
lz_en  in  1  leading-zero blanking enable
digits_bcd  in  4*DIGITS  packed BCD digits, digit i at [4i+3:4i]
dp_mask  in  DIGITS  decimal point per digit, 1 = on
seg_n  out  7  segments {g,f,e,d,c,b,a}, active low
dp_n  out  1  decimal point, active low
com_n  out  DIGITS  digit commons, active low, at most one low
digit_idx  out  3  index of the slot currently driven
frame_done  out  1  one-cycle pulse at the end of slot DIGITS-1

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. Reset values: seg_n=7'h7F, dp_n=1, com_n=all 1, digit_idx=0, frame_done=0, prescaler=0, snapshot=0, state=OFF.
- States: OFF (en=0), BLANK (prescaler < BLANK_CYC), SHOW (prescaler >= BLANK_CYC).
- Prescaler counts 0..SCAN_DIV-1 while en=1. At SCAN_DIV-1 it wraps to 0 and the index advances. The index wraps from DIGITS-1 to 0.
- frame_done asserts for exactly the one cycle in which the prescaler wraps with index=DIGITS-1.
- Priority, highest first: rst, en=0, sync_clr, wrap.
  - sync_clr=1: next prescaler=0, next index=0, no frame_done.
  - en=0: same as sync_clr, and the state goes to OFF.
  - Deasserting en mid-slot aborts the slot.
  - A rising en starts at slot 0, prescaler 0.
- Snapshot: digits_bcd and dp_mask are captured in the cycle where prescaler=0 and index=0, including the first cycle after en rises or sync_clr. Displayed data changes only at frame boundaries.
- Output pipeline: all outputs are registered and reflect the prescaler/index/state of the previous cycle (1-cycle latency).
  - com_n[idx]=0 only in SHOW. BLANK and OFF drive all commons and segments off.
  - digit_idx follows the same registered timing as com_n.
- Decode of the snapshot digit:
  - 0-9 use the standard patterns, e.g. 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000.
  - Codes 10-15 -> dash 7'b0111111.
- Leading-zero blanking: when lz_en=1 and idx>0 and all snapshot digits idx..DIGITS-1 are 0, segments are off. The common is still driven and dp still follows dp_mask. Digit 0 is never blanked.
- dp_n = ~dp_mask_snapshot[idx] in SHOW, 1 otherwise.
- Widths: index compare and wrap are done at 3 bits. Prescaler compare uses SCAN_DIV-1 truncated to PW.
- Simultaneous sync_clr and wrap: sync_clr wins and frame_done stays 0.
- Reset mid-slot: everything returns to reset values immediately (asynchronous).

Decomposition:
- Shared package disp_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_DASH=7'b0111111, SEG_OFF=7'h7F;
  - state encoding OFF/BLANK/SHOW;
  - the MAX_DIGITS=8 limit.
- One combinational sub-module, bcd7seg_dec (4-bit in, 7-bit active-low out), is instantiated once. It is reusable by other display blocks.

Test Plan:
Sim config for all scenarios: DIGITS=6, SCAN_DIV=16, BLANK_CYC=2.
1. Reset then en=1, digits_bcd=24'h123456 -> each slot shows 2 blank cycles then 14 cycles of com_n with one low bit, rotating 0..5. Slot 0 seg_n=SEG_6, slot 5 seg_n=SEG_1. frame_done pulses once every 96 cycles.
2. digits_bcd=24'h000042, lz_en=1 -> slots 2..5 have seg_n=7'h7F with commons still active. Slot 1=SEG_4, slot 0=SEG_2. With lz_en=0, slots 2..5 show SEG_0.
3. Change digits_bcd mid-frame (during slot 3) -> displayed values are unchanged until the next slot-0 capture, then the new values appear.
4. sync_clr pulsed in the same cycle as the slot-5 wrap -> frame_done stays 0, the next slot is 0 with prescaler 0, and a fresh snapshot is taken.
5. Digit value 4'hC with dp_mask=6'b000100 -> slot 2 seg_n=7'b0111111 and dp_n=0. dp_n=1 in all other slots and during blank cycles.
6. en dropped during slot 4 SHOW -> next cycle com_n=6'h3F and seg_n=7'h7F. en re-raised -> scanning restarts at slot 0. An async rst pulse mid-slot -> outputs go to reset values with no clock edge.
